// File: rtl/cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter
//
// Purpose:
//   Shares one external CPU bus between NUM_PORTS requesters (for example CPU
//   fetch, CPU memory stage, DMA and video). Whole transactions are
//   serialised, so exactly one port owns the bus at a time. Arbitration is
//   round-robin: the port that was granted last becomes lowest priority, so
//   no requester can be starved.
//
// Parameters:
//   NUM_PORTS       number of requester ports (2..8)
//   TIMEOUT_CYCLES  bus-ready watchdog limit (only used with the macro below)
//
// Optional feature:
//   CPU_BUS_ARBITER_TIMEOUT_EN  when defined, a bus cycle that sees no
//   i_bus_ready for TIMEOUT_CYCLES cycles is aborted: the port gets ready with
//   rdata 32'hDEADBEEF and o_timeout pulses for one cycle. When undefined the
//   arbiter waits for i_bus_ready indefinitely and o_timeout is tied to 0.
//
// Ports:
//   i_clock         system clock, rising edge
//   i_reset         synchronous active-low reset
//   i_port_rw       per-port write enable (1 = write), bit p = port p
//   i_port_request  per-port request level
//   o_port_ready    per-port completion flag (at most one bit set)
//   i_port_address  per-port address, port p in bits [32p+31:32p]
//   i_port_wdata    per-port write data, same packing
//   o_port_rdata    read data of the last completed transaction (shared)
//   o_bus_rw        bus write enable
//   o_bus_request   bus request
//   i_bus_ready     bus transaction complete
//   o_bus_address   bus address
//   i_bus_rdata     bus read data
//   o_bus_wdata     bus write data
//   o_timeout       one-cycle abort pulse
//
// Port handshake (request/ready):
//   A port raises request and holds rw/address/wdata stable until it samples
//   its ready bit high, then drops request. Ready stays high until the arbiter
//   samples that port's request low, so a port always sees at least one cycle
//   of ready and is never re-granted while its ready is still high.
// -----------------------------------------------------------------------------
module cpu_bus_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NUM_PORTS-1:0]      i_port_rw,
    input  logic [NUM_PORTS-1:0]      i_port_request,
    output logic [NUM_PORTS-1:0]      o_port_ready,
    input  logic [32*NUM_PORTS-1:0]   i_port_address,
    input  logic [32*NUM_PORTS-1:0]   i_port_wdata,
    output logic [31:0]               o_port_rdata,
    output logic                      o_bus_rw,
    output logic                      o_bus_request,
    input  logic                      i_bus_ready,
    output logic [31:0]               o_bus_address,
    input  logic [31:0]               i_bus_rdata,
    output logic [31:0]               o_bus_wdata,
    output logic                      o_timeout
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Elaboration-time sanity check of the configuration.
    if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_config
        $error("cpu_bus_arbiter: NUM_PORTS must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [IDX_W-1:0]       grant;
    logic [IDX_W-1:0]       grant_next;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       last_grant_next;

    logic [NUM_PORTS-1:0]   port_ready_next;
    logic [31:0]            port_rdata_next;
    logic                   bus_rw_next;
    logic                   bus_request_next;
    logic [31:0]            bus_address_next;
    logic [31:0]            bus_wdata_next;

    // One-hot of the current owner, used when completing a transaction.
    logic [NUM_PORTS-1:0]   grant_onehot;

`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]       wait_cnt;
    logic [CNT_W-1:0]       wait_cnt_next;
    logic                   timeout_next;
`endif

    // -------------------------------------------------------------------------
    // Round-robin pick: scan from last_grant+1 upward, wrapping, and take the
    // first requesting port. The port granted last is visited last.
    // -------------------------------------------------------------------------
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    int                     cand;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!pick_valid && i_port_request[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        grant_onehot        = '0;
        grant_onehot[grant] = 1'b1;
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state;
        grant_next       = grant;
        last_grant_next  = last_grant;
        port_ready_next  = o_port_ready;
        port_rdata_next  = o_port_rdata;
        bus_rw_next      = o_bus_rw;
        bus_request_next = o_bus_request;
        bus_address_next = o_bus_address;
        bus_wdata_next   = o_bus_wdata;
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
        wait_cnt_next    = wait_cnt;
        timeout_next     = 1'b0;
`endif

        case (state)
            ST_IDLE: begin
                port_ready_next = '0;
                if (pick_valid) begin
                    grant_next       = pick_idx;
                    last_grant_next  = pick_idx;
                    bus_rw_next      = i_port_rw[pick_idx];
                    bus_address_next = i_port_address[int'(pick_idx)*32 +: 32];
                    bus_wdata_next   = i_port_wdata[int'(pick_idx)*32 +: 32];
                    bus_request_next = 1'b1;
                    state_next       = ST_BUS;
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
                    wait_cnt_next    = '0;
`endif
                end else begin
                    bus_request_next = 1'b0;
                end
            end

            ST_BUS: begin
                // Address/data stay registered; only completion is watched.
                // Writes also capture i_bus_rdata; the port ignores it.
                if (i_bus_ready) begin
                    port_rdata_next  = i_bus_rdata;
                    bus_request_next = 1'b0;
                    port_ready_next  = grant_onehot;
                    state_next       = ST_DONE;
                end
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
                else if (wait_cnt == CNT_LAST) begin
                    // Abandon the bus cycle and complete the port with a
                    // recognisable poison value.
                    port_rdata_next  = 32'hDEADBEEF;
                    bus_request_next = 1'b0;
                    port_ready_next  = grant_onehot;
                    timeout_next     = 1'b1;
                    state_next       = ST_DONE;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
`endif
            end

            ST_DONE: begin
                // A port that already dropped request during BUS leaves here
                // after exactly one ready cycle.
                if (!i_port_request[grant]) begin
                    port_ready_next = '0;
                    state_next      = ST_IDLE;
                end
            end

            default: begin
                port_ready_next  = '0;
                bus_request_next = 1'b0;
                state_next       = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state         <= ST_IDLE;
            grant         <= '0;
            last_grant    <= IDX_W'(NUM_PORTS - 1);
            o_port_ready  <= '0;
            o_port_rdata  <= '0;
            o_bus_rw      <= 1'b0;
            o_bus_request <= 1'b0;
            o_bus_address <= '0;
            o_bus_wdata   <= '0;
        end else begin
            state         <= state_next;
            grant         <= grant_next;
            last_grant    <= last_grant_next;
            o_port_ready  <= port_ready_next;
            o_port_rdata  <= port_rdata_next;
            o_bus_rw      <= bus_rw_next;
            o_bus_request <= bus_request_next;
            o_bus_address <= bus_address_next;
            o_bus_wdata   <= bus_wdata_next;
        end
    end

`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            wait_cnt  <= '0;
            o_timeout <= 1'b0;
        end else begin
            wait_cnt  <= wait_cnt_next;
            o_timeout <= timeout_next;
        end
    end
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_arbiter
//
// Directed bench for cpu_bus_arbiter. A transaction-level reference model
// (owner / completed / wait count) predicts every output each cycle and a
// single compare process checks the DUT on the falling edge. Directed
// sequences add literal expectations for latency, data values, grant order,
// reset behaviour, the watchdog and the late-drop protocol violation.
// -----------------------------------------------------------------------------
module tb_cpu_bus_arbiter;

    localparam int NP = 4;
    localparam int TO = 16;
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic                 clk;
    logic                 rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT signals
    logic [NP-1:0]        port_rw;
    logic [NP-1:0]        port_req;
    logic [NP-1:0]        port_ready;
    logic [32*NP-1:0]     port_addr;
    logic [32*NP-1:0]     port_wdata;
    logic [31:0]          port_rdata;
    logic                 bus_rw;
    logic                 bus_req;
    logic                 bus_ready;
    logic [31:0]          bus_addr;
    logic [31:0]          bus_rdata;
    logic [31:0]          bus_wdata;
    logic                 timeout;

    cpu_bus_arbiter #(
        .NUM_PORTS      (NP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_port_rw      (port_rw),
        .i_port_request (port_req),
        .o_port_ready   (port_ready),
        .i_port_address (port_addr),
        .i_port_wdata   (port_wdata),
        .o_port_rdata   (port_rdata),
        .o_bus_rw       (bus_rw),
        .o_bus_request  (bus_req),
        .i_bus_ready    (bus_ready),
        .o_bus_address  (bus_addr),
        .i_bus_rdata    (bus_rdata),
        .o_bus_wdata    (bus_wdata),
        .o_timeout      (timeout)
    );

    // -------------------------------------------------------------------------
    // Scoreboard bookkeeping
    // -------------------------------------------------------------------------
    int tests_run    = 0;
    int tests_failed = 0;
    bit chk_en       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: who owns the bus, whether its transfer has completed,
    // and how long it has waited. Outputs follow directly from those.
    // -------------------------------------------------------------------------
    int              m_owner;
    bit              m_done;
    int              m_wait;
    int              m_last;
    int              m_pick;
    logic            e_req;
    logic            e_rw;
    logic [31:0]     e_addr;
    logic [31:0]     e_wdata;
    logic [31:0]     e_rdata;
    logic [NP-1:0]   e_ready;
    logic            e_to;

    function automatic int find_next(input int last, input logic [NP-1:0] req);
        int c;
        for (int k = 1; k <= NP; k++) begin
            c = (last + k) % NP;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    assign m_pick = find_next(m_last, port_req);

    always @(posedge clk) begin
        if (!rst) begin
            m_owner <= -1;
            m_done  <= 1'b0;
            m_wait  <= 0;
            m_last  <= NP - 1;
            e_req   <= 1'b0;
            e_rw    <= 1'b0;
            e_addr  <= '0;
            e_wdata <= '0;
            e_rdata <= '0;
            e_ready <= '0;
            e_to    <= 1'b0;
        end else begin
            e_to <= 1'b0;
            if (m_owner < 0) begin
                if (m_pick >= 0) begin
                    m_owner <= m_pick;
                    m_last  <= m_pick;
                    m_done  <= 1'b0;
                    m_wait  <= 0;
                    e_req   <= 1'b1;
                    e_rw    <= port_rw[m_pick];
                    e_addr  <= port_addr[32*m_pick +: 32];
                    e_wdata <= port_wdata[32*m_pick +: 32];
                end
            end else if (!m_done) begin
                if (bus_ready) begin
                    e_rdata <= bus_rdata;
                    e_req   <= 1'b0;
                    e_ready <= onehot(m_owner);
                    m_done  <= 1'b1;
                end else if (TO_EN && m_wait == TO - 1) begin
                    e_rdata <= 32'hDEADBEEF;
                    e_req   <= 1'b0;
                    e_ready <= onehot(m_owner);
                    e_to    <= 1'b1;
                    m_done  <= 1'b1;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end else if (!port_req[m_owner]) begin
                e_ready <= '0;
                m_owner <= -1;
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_bus_request", {31'd0, bus_req},   {31'd0, e_req});
            check("cyc_bus_rw",      {31'd0, bus_rw},    {31'd0, e_rw});
            check("cyc_bus_address", bus_addr,           e_addr);
            check("cyc_bus_wdata",   bus_wdata,          e_wdata);
            check("cyc_port_rdata",  port_rdata,         e_rdata);
            check("cyc_port_ready",  {28'd0, port_ready}, {28'd0, e_ready});
            check("cyc_timeout",     {31'd0, timeout},   {31'd0, e_to});
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int p, input logic rw, input logic [31:0] addr,
                              input logic [31:0] wdata);
        port_rw[p]             = rw;
        port_addr[32*p +: 32]  = addr;
        port_wdata[32*p +: 32] = wdata;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        tests_failed++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // -------------------------------------------------------------------------
    // Directed sequences
    // -------------------------------------------------------------------------
    logic [2:0] exp_q[$];
    logic [2:0] got_q[$];
    int         cnt;
    int         n;
    bit         seen;
    bit         dup;

    initial begin
        rst        = 1'b0;
        port_rw    = '0;
        port_req   = '0;
        port_addr  = '0;
        port_wdata = '0;
        bus_ready  = 1'b0;
        bus_rdata  = '0;
        step();
        step();
        chk_en = 1'b1;
        check("reset_bus_request", {31'd0, bus_req}, 32'd0);
        check("reset_port_ready",  {28'd0, port_ready}, 32'd0);
        rst = 1'b1;
        step();

        // ---- single read on port 1, three wait cycles ----
        drive_port(1, 1'b0, 32'h0000_0100, 32'h0);
        port_req[1] = 1'b1;
        cnt = 0;
        step();
        if (bus_req) cnt++;
        check("t1_bus_address", bus_addr, 32'h0000_0100);
        repeat (3) begin
            step();
            if (bus_req) cnt++;
        end
        bus_ready = 1'b1;
        bus_rdata = 32'h1234_5678;
        step();
        if (bus_req) cnt++;
        bus_ready = 1'b0;
        check("t1_request_cycles", cnt, 32'd4);
        check("t1_ready",          {28'd0, port_ready}, 32'b0010);
        check("t1_rdata",          port_rdata, 32'h1234_5678);
        port_req[1] = 1'b0;
        step();
        check("t1_ready_release",  {28'd0, port_ready}, 32'd0);
        step();

        // ---- write on port 2, zero-wait bus ----
        drive_port(2, 1'b1, 32'h0000_2000, 32'hCAFE_F00D);
        port_req[2] = 1'b1;
        bus_ready   = 1'b1;
        step();
        check("t2_bus_rw",     {31'd0, bus_rw}, 32'd1);
        check("t2_bus_wdata",  bus_wdata, 32'hCAFE_F00D);
        check("t2_ready_early", {28'd0, port_ready}, 32'd0);
        step();
        check("t2_ready_2edges", {28'd0, port_ready}, 32'b0100);
        port_req[2] = 1'b0;
        bus_ready   = 1'b0;
        step();
        step();

        // ---- fairness: all four ports keep requesting ----
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int p = 0; p < NP; p++) begin
            drive_port(p, 1'b0, 32'h1000 * (p + 1), 32'h0);
        end
        exp_q     = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
        bus_ready = 1'b1;
        port_req  = '1;
        for (int c = 0; c < 60 && got_q.size() < 6; c++) begin
            step();
            for (int p = 0; p < NP; p++) begin
                if (port_ready[p] && port_req[p]) begin
                    got_q.push_back(3'(p));
                    port_req[p] = 1'b0;
                end else if (!port_req[p] && !port_ready[p]) begin
                    port_req[p] = 1'b1;
                end
            end
        end
        check("t3_grant_count", got_q.size(), 32'd6);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("t3_grant_order", {29'd0, got_q[i]}, {29'd0, exp_q[i]});
        end
        dup = 1'b0;
        for (int i = 0; i + 3 < got_q.size(); i++) begin
            for (int a = i; a < i + 4; a++) begin
                for (int b = a + 1; b < i + 4; b++) begin
                    if (got_q[a] == got_q[b]) dup = 1'b1;
                end
            end
        end
        check("t3_window_distinct", {31'd0, dup}, 32'd0);
        port_req  = '0;
        bus_ready = 1'b0;
        repeat (3) step();

        // ---- reset in the middle of a bus cycle ----
        port_req[0] = 1'b1;
        step();
        port_req[1] = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("t4_rst_bus_request", {31'd0, bus_req}, 32'd0);
        check("t4_rst_bus_address", bus_addr, 32'd0);
        check("t4_rst_port_rdata",  port_rdata, 32'd0);
        check("t4_rst_port_ready",  {28'd0, port_ready}, 32'd0);
        rst = 1'b1;
        step();
        check("t4_first_grant_port0", bus_addr, 32'h0000_1000);
        bus_ready = 1'b1;
        step();
        check("t4_ready0", {28'd0, port_ready}, 32'b0001);
        port_req[0] = 1'b0;
        bus_ready   = 1'b0;
        step();
        bus_ready = 1'b1;
        step();
        check("t4_then_port1", bus_addr, 32'h0000_2000);
        step();
        port_req[1] = 1'b0;
        bus_ready   = 1'b0;
        step();
        step();

        // ---- bus never answers ----
        port_req[3] = 1'b1;
        step();
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
        n    = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            step();
            if (timeout) begin
                seen = 1'b1;
                n    = i;
            end
        end
        check("t5_timeout_steps", n, 32'd16);
        check("t5_timeout_rdata", port_rdata, 32'hDEADBEEF);
        check("t5_timeout_ready", {28'd0, port_ready}, 32'b1000);
        check("t5_timeout_busreq", {31'd0, bus_req}, 32'd0);
        step();
        check("t5_timeout_pulse", {31'd0, timeout}, 32'd0);
        port_req[3] = 1'b0;
        step();
        step();
`else
        repeat (100) step();
        check("t5_still_requesting", {31'd0, bus_req}, 32'd1);
        check("t5_no_timeout",       {31'd0, timeout}, 32'd0);
        bus_ready = 1'b1;
        step();
        bus_ready   = 1'b0;
        port_req[3] = 1'b0;
        step();
        step();
`endif

        // ---- port 0 drops request during BUS ----
        port_req[0] = 1'b1;
        step();
        step();
        port_req[0] = 1'b0;
        step();
        bus_ready = 1'b1;
        bus_rdata = 32'hA5A5_0001;
        step();
        bus_ready = 1'b0;
        cnt = port_ready[0] ? 1 : 0;
        repeat (4) begin
            step();
            if (port_ready[0]) cnt++;
        end
        check("t6_ready_one_cycle", cnt, 32'd1);
        check("t6_late_rdata", port_rdata, 32'hA5A5_0001);
        check("t6_idle_no_request", {31'd0, bus_req}, 32'd0);

        step();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
